// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   DATA_W   width of a CPU data word
//   WAIT_W   width of the wait-state counter (WAIT_CYCLES range 0..15)
//   WORD_W   width of one storage word (DATA_W, or DATA_W+1 when the
//            optional DMEM_PARITY_EN macro adds an even-parity bit)
//   state_t  responder FSM encoding
//   parity() even-parity bit over a data word
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int WAIT_W = 4;

`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Bit that makes the total number of ones (data + parity) even.
  function automatic logic parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU MEM stage (master) and the data-memory
// responder (slave).
//   req_valid/req_ready   request handshake, request held until accepted
//   req_write             1 = store, 0 = load
//   req_addr              byte address
//   req_wdata             store data
//   resp_valid/resp_ready response handshake, response held until taken
//   resp_rdata            load data, zero for stores and errors
//   resp_err              misaligned or out-of-range address
//   resp_perr             load parity error (only with DMEM_PARITY_EN)
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [15:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
`ifdef DMEM_PARITY_EN
  logic              resp_perr;
`endif

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
`ifdef DMEM_PARITY_EN
    , input resp_perr
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
`ifdef DMEM_PARITY_EN
    , output resp_perr
`endif
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: synchronous write,
// registered read, no reset on contents.
// With DMEM_PARITY_EN defined each word carries an even-parity bit above
// the data, generated here on every write.
//   clock  storage clock
//   we     write word at addr with wdata
//   re     capture word at addr into rdata
//   addr   word index
//   wdata  data to store (parity appended internally)
//   rdata  registered read word (WORD_W bits)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] wword;

`ifdef DMEM_PARITY_EN
  assign wword = {parity(wdata), wdata};
`else
  assign wword = wdata;
`endif

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wword;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the 16-bit CPU load/store path.
// One request at a time: IDLE -> WAIT (WAIT_CYCLES cycles, skipped when 0)
// -> ACCESS -> RESP -> IDLE. Address errors are reported, never aliased.
// Optional macro DMEM_PARITY_EN: parity-protected storage and resp_perr.
//   clock    single clock, posedge
//   reset_n  asynchronous active-low reset
//   bus      slave side of data_mem_responder_if
// Parameters: ADDR_W (word-index width), WAIT_CYCLES (0..15).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_err;
  logic              load_ok;

  logic              lat_write;
  logic [15:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              addr_err;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_q;

  // Odd byte addresses are misaligned; any set bit above the word index
  // is outside the storage.
  function automatic logic addr_error(input logic [15:0] addr);
    return addr[0] | ((addr >> (ADDR_W + 1)) != 16'd0);
  endfunction

  assign addr_err = addr_error(lat_addr);

  // Storage is touched only in ACCESS and only for a legal address, so an
  // aborted or faulty request never changes memory.
  assign mem_we = (state == ST_ACCESS) & lat_write & ~addr_err;
  assign mem_re = (state == ST_ACCESS) & ~lat_write & ~addr_err;

  // Request capture at the accept edge
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && bus.req_valid && req_ready) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      load_ok    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACCESS;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WAIT_W'(1)) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= addr_err;
          load_ok    <= ~lat_write & ~addr_err;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            load_ok    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (lat_addr[ADDR_W:1]),
    .wdata (lat_wdata),
    .rdata (mem_q)
  );

  // The read register holds its word through RESP; load_ok gates it so
  // stores, errors and the post-reset state all present zero.
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_err;
  assign bus.resp_rdata = load_ok ? mem_q[DATA_W-1:0] : '0;

`ifdef DMEM_PARITY_EN
  assign bus.resp_perr = load_ok & (mem_q[DATA_W] != parity(mem_q[DATA_W-1:0]));
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 0, 3)
// share one stimulus set selected by 'sel'. The driver pushes expected
// responses into a queue; a negedge monitor pops and compares each
// accepted response.
module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  int          sel;
  logic        req_valid, req_write, resp_ready;
  logic [15:0] req_addr, req_wdata;

  logic        m_req_ready, m_resp_valid, m_resp_err, m_resp_perr;
  logic [15:0] m_rdata;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus2 ();

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (.clock(clock), .reset_n(reset_n), .bus(bus1));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  always #5 clock = ~clock;

  assign bus0.req_valid = req_valid & (sel == 0);
  assign bus1.req_valid = req_valid & (sel == 1);
  assign bus2.req_valid = req_valid & (sel == 2);
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus0.resp_ready = (sel == 0) ? resp_ready : 1'b1;
  assign bus1.resp_ready = (sel == 1) ? resp_ready : 1'b1;
  assign bus2.resp_ready = (sel == 2) ? resp_ready : 1'b1;

  assign m_req_ready  = (sel == 0) ? bus0.req_ready  : (sel == 1) ? bus1.req_ready  : bus2.req_ready;
  assign m_resp_valid = (sel == 0) ? bus0.resp_valid : (sel == 1) ? bus1.resp_valid : bus2.resp_valid;
  assign m_resp_err   = (sel == 0) ? bus0.resp_err   : (sel == 1) ? bus1.resp_err   : bus2.resp_err;
  assign m_rdata      = (sel == 0) ? bus0.resp_rdata : (sel == 1) ? bus1.resp_rdata : bus2.resp_rdata;
`ifdef DMEM_PARITY_EN
  assign m_resp_perr  = (sel == 0) ? bus0.resp_perr  : (sel == 1) ? bus1.resp_perr  : bus2.resp_perr;
`else
  assign m_resp_perr  = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic        perr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] model [3][256];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          acc_cyc = 0;
  logic        prev_v = 1'b0;
  logic        perr_expect = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clock) begin
    if (reset_n && m_resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL resp_unexpected: got rdata %0h err %0b with no request outstanding", m_rdata, m_resp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", m_rdata, mon_e.rdata);
        check("resp_err", m_resp_err, mon_e.err);
`ifdef DMEM_PARITY_EN
        check("resp_perr", m_resp_perr, mon_e.perr);
`endif
      end
    end
    if (m_resp_valid && !prev_v) rise_cyc = cyc;
    prev_v = m_resp_valid;
  end

  // Issue one request; expectation comes from the reference model.
  task automatic send(input bit do_push, input bit b2b, input logic w,
                      input logic [15:0] a, input logic [15:0] d, input logic ee);
    exp_t       x;
    logic [7:0] idx;
    bit         ok;
    idx = a[8:1];
    if (do_push) begin
      x.err   = ee;
      x.rdata = 16'h0000;
      x.perr  = perr_expect & ~w & ~ee;
      if (!ee) begin
        if (w) model[sel][idx] = d;
        else   x.rdata = model[sel][idx];
      end
      exp_q.push_back(x);
    end
    if (!b2b) begin
      @(posedge clock);
      #1;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (m_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_within_budget", ok, 1'b1);
    acc_cyc = cyc;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Wait for return to IDLE; report busy cycles and accept-to-valid latency.
  task automatic finish_x(output int lat, output int low);
    bit ok;
    low = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (m_req_ready) begin
        ok = 1'b1;
        break;
      end
      low++;
    end
    check("idle_within_budget", ok, 1'b1);
    lat = rise_cyc - acc_cyc;
  endtask

  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic ee, output int lat, output int low);
    send(1'b1, 1'b0, w, a, d, ee);
    finish_x(lat, low);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("resp_valid_within_budget", ok, 1'b1);
  endtask

  task automatic burst(input int wait_cycles);
    logic [15:0] vec [8];
    int          prev;
    bit          ok;
    vec = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234, 16'hA5A5, 16'h5A5A, 16'h00FF, 16'hFF00};
    for (int i = 0; i < 16; i++) begin
      send(1'b1, (i != 0), (i < 8), 16'h0080 + 16'(2 * (i % 8)), vec[i % 8], 1'b0);
      if (i != 0) check("b2b_interval", acc_cyc - prev, wait_cycles + 3);
      prev = acc_cyc;
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && m_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_drained", ok, 1'b1);
  endtask

  int lat, low;

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; sel = 0; reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_req_ready", m_req_ready, 1'b1);
    check("rst_resp_valid", m_resp_valid, 1'b0);
    check("rst_rdata", m_rdata, 16'h0000);
    check("rst_err", m_resp_err, 1'b0);
    check("rst_perr", m_resp_perr, 1'b0);

    // Store then load, WAIT_CYCLES=1
    xact(1'b1, 16'h0004, 16'h00AB, 1'b0, lat, low);
    check("sw_busy_cycles", low, 3);
    check("sw_latency", lat, 3);
    xact(1'b0, 16'h0004, 16'h0000, 1'b0, lat, low);
    check("lw_latency", lat, 3);

    // Address errors
    xact(1'b1, 16'h0000, 16'h0F0F, 1'b0, lat, low);
    xact(1'b0, 16'h0003, 16'h0000, 1'b1, lat, low);
    xact(1'b1, 16'h0200, 16'hDEAD, 1'b1, lat, low);
    xact(1'b0, 16'h0000, 16'h0000, 1'b0, lat, low);
    xact(1'b0, 16'h8004, 16'h0000, 1'b1, lat, low);
    xact(1'b1, 16'h01FE, 16'hBEEF, 1'b0, lat, low);
    xact(1'b0, 16'h01FE, 16'h0000, 1'b0, lat, low);

    // Response back-pressure with a second request waiting
    xact(1'b1, 16'h0006, 16'h3C3C, 1'b0, lat, low);
    send(1'b1, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0);
    resp_ready = 1'b0;
    wait_valid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0004;
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_valid", m_resp_valid, 1'b1);
      check("stall_rdata", m_rdata, 16'h3C3C);
      check("stall_req_ready", m_req_ready, 1'b0);
      @(negedge clock);
    end
    @(posedge clock);
    #1 resp_ready = 1'b1;
    send(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    finish_x(lat, low);

    // Reset in WAIT of a store: not committed
    xact(1'b1, 16'h0010, 16'h5A5A, 1'b0, lat, low);
    send(1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0);
    reset_n = 1'b0;
    @(negedge clock);
    check("abort_resp_valid", m_resp_valid, 1'b0);
    check("abort_rdata", m_rdata, 16'h0000);
    check("abort_err", m_resp_err, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("abort_req_ready", m_req_ready, 1'b1);
    xact(1'b0, 16'h0010, 16'h0000, 1'b0, lat, low);

    // Reset while a load response is held
    resp_ready = 1'b0;
    send(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_valid();
    check("held_rdata", m_rdata, 16'h5A5A);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check("rst_resp_resp_valid", m_resp_valid, 1'b0);
    check("rst_resp_rdata", m_rdata, 16'h0000);
    @(posedge clock);
    #1 reset_n = 1'b1;
    resp_ready = 1'b1;
    @(negedge clock);
    check("rst_resp_req_ready", m_req_ready, 1'b1);

    // Latency and throughput, WAIT_CYCLES=0
    sel = 1;
    xact(1'b1, 16'h0020, 16'h1111, 1'b0, lat, low);
    check("w0_latency", lat, 2);
    check("w0_busy_cycles", low, 2);
    xact(1'b0, 16'h0020, 16'h0000, 1'b0, lat, low);
    check("w0_lw_latency", lat, 2);
    burst(0);

    // Latency and throughput, WAIT_CYCLES=3
    sel = 2;
    xact(1'b1, 16'h0020, 16'h2222, 1'b0, lat, low);
    check("w3_latency", lat, 5);
    check("w3_busy_cycles", low, 5);
    xact(1'b0, 16'h0020, 16'h0000, 1'b0, lat, low);
    check("w3_lw_latency", lat, 5);
    burst(3);

`ifdef DMEM_PARITY_EN
    // Parity: clean word, then a single flipped stored bit
    sel = 0;
    xact(1'b1, 16'h0040, 16'h00F0, 1'b0, lat, low);
    xact(1'b0, 16'h0040, 16'h0000, 1'b0, lat, low);
    u_w1.u_array.mem[8'h20][3] = ~u_w1.u_array.mem[8'h20][3];
    model[0][8'h20][3] = ~model[0][8'h20][3];
    perr_expect = 1'b1;
    xact(1'b0, 16'h0040, 16'h0000, 1'b0, lat, low);
    perr_expect = 1'b0;
    xact(1'b1, 16'h0042, 16'h7777, 1'b0, lat, low);
    xact(1'b0, 16'h0042, 16'h0000, 1'b0, lat, low);
`endif

    repeat (2) @(negedge clock);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
